// File: rtl/pov_column_prefetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pov_column_prefetch                                        |
// | Description : Double-buffered LED column prefetcher for the POV display. |
// |               On each change of the angle index a full column is read    |
// |               from the selected pixel source, scaled by a global         |
// |               brightness and written to the back buffer. The buffers     |
// |               then swap, and the neopixel controller reads the stable    |
// |               front buffer.                                              |
// | Ports       : clk, rst_n      - clock, async active-low reset            |
// |               theta           - current angle index                      |
// |               src_sel         - pixel source select (latched per fetch)  |
// |               brightness      - global brightness, 255 = unity           |
// |               overrun_clr     - clears the sticky overrun flag           |
// |               rd_addr/rd_src  - source read request                      |
// |               rd_data         - source data, 1-cycle latency             |
// |               px_idx/px_out   - front-buffer read port, 1-cycle latency  |
// |               col_ready       - pulse when a new column is swapped in    |
// |               busy            - fetch/drain/swap in progress             |
// |               overrun         - theta moved during a fetch (sticky)      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pov_column_prefetch #(
  parameter  int LED_COUNT  = 52,
  parameter  int TEX_WIDTH  = 256,
  parameter  int THETA_BITS = 6,
  parameter  int NUM_SRC    = 2,
  parameter  int PX_BITS    = 24,
  localparam int SW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int AW         = $clog2(TEX_WIDTH * LED_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [THETA_BITS-1:0] theta,
  input  logic [SW-1:0]         src_sel,
  input  logic [7:0]            brightness,
  input  logic                  overrun_clr,
  output logic [AW-1:0]         rd_addr,
  output logic [SW-1:0]         rd_src,
  input  logic [PX_BITS-1:0]    rd_data,
  input  logic [5:0]            px_idx,
  output logic [PX_BITS-1:0]    px_out,
  output logic                  col_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int            CW          = $clog2(TEX_WIDTH);
  localparam int            KW          = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam int            NB          = PX_BITS / 8;
  localparam logic [KW-1:0] C_K_LAST    = KW'(LED_COUNT - 1);
  localparam logic [6:0]    C_LED_COUNT = 7'(LED_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_start;

  logic [THETA_BITS-1:0] r_theta_q;
  logic                r_first;
  logic                r_pending;
  logic                r_overrun;
  logic [KW-1:0]       r_k;
  logic [CW-1:0]       r_col_l;
  logic [SW-1:0]       r_rd_src;
  logic [AW-1:0]       r_rd_addr;
  logic                r_wr_valid;
  logic [KW-1:0]       r_wr_idx;
  logic                r_front;
  logic [PX_BITS-1:0]  r_px_out;
  logic [PX_BITS-1:0]  r_buf [2][LED_COUNT];

  logic                w_chg;
  logic                w_event;
  logic [CW-1:0]       w_col;
  logic [8:0]          w_gain;
  logic [PX_BITS-1:0]  w_scaled;

  assign w_chg   = (theta != r_theta_q);
  assign w_event = w_chg | r_first;

  // Angle-to-column mapping, done at full width before truncation so it is
  // correct whether the angle index is narrower or wider than the column index.
  assign w_col = CW'({theta, {CW{1'b0}}} >> THETA_BITS);

  // Per-byte scaling by (brightness+1)/256: 255 is an exact identity.
  assign w_gain = {1'b0, brightness} + 9'd1;

  for (genvar b = 0; b < NB; b++) begin : g_scale
    assign w_scaled[8*b +: 8] = 8'(({8'd0, rd_data[8*b +: 8]} * {7'd0, w_gain}) >> 8);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and status outputs. A theta change seen in the swap cycle is
  // folded into the restart decision so it is not lost.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    busy         = 1'b1;
    col_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_event || r_pending) begin
          w_start      = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (r_k == C_K_LAST) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        w_next_state = S_SWAP;
      end
      S_SWAP: begin
        col_ready = 1'b1;
        if (w_event || r_pending) begin
          w_start      = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Fetch control, address generation and write-back pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_theta_q  <= '0;
      r_first    <= 1'b1;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
      r_k        <= '0;
      r_col_l    <= '0;
      r_rd_src   <= '0;
      r_rd_addr  <= '0;
      r_wr_valid <= 1'b0;
      r_wr_idx   <= '0;
      r_front    <= 1'b0;
    end else begin
      r_theta_q <= theta;

      if (w_start) begin
        // Column and source are frozen here for the whole fetch.
        r_first   <= 1'b0;
        r_pending <= 1'b0;
        r_k       <= '0;
        r_col_l   <= w_col;
        r_rd_src  <= src_sel;
        r_rd_addr <= AW'(w_col);
      end else begin
        if (busy && w_chg) r_pending <= 1'b1;
        if (r_state == S_FETCH && r_k != C_K_LAST) begin
          r_k       <= r_k + KW'(1);
          r_rd_addr <= AW'((32'(r_k) + 32'd1) * 32'(TEX_WIDTH) + 32'(r_col_l));
        end
      end

      if (busy && w_chg)    r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;

      // Source data arrives one cycle after its address.
      r_wr_valid <= (r_state == S_FETCH);
      r_wr_idx   <= r_k;

      if (r_state == S_SWAP) r_front <= ~r_front;
    end
  end

  // Line store and front-buffer read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LED_COUNT; i++) begin
        r_buf[0][i] <= '0;
        r_buf[1][i] <= '0;
      end
      r_px_out <= '0;
    end else begin
      if (r_wr_valid) r_buf[~r_front][r_wr_idx] <= w_scaled;
      if ({1'b0, px_idx} < C_LED_COUNT) r_px_out <= r_buf[r_front][px_idx[KW-1:0]];
      else                              r_px_out <= '0;
    end
  end

  assign rd_addr = r_rd_addr;
  assign rd_src  = r_rd_src;
  assign px_out  = r_px_out;
  assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pov_column_prefetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pov_column_prefetch                                     |
// | Description : Self-checking bench for pov_column_prefetch. A clocked     |
// |               source memory answers read requests; expected pixels come  |
// |               from an arithmetic model of angle, source and brightness.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pov_column_prefetch;

  localparam int LED_COUNT  = 52;
  localparam int TEX_WIDTH  = 256;
  localparam int THETA_BITS = 6;
  localparam logic [23:0] CONST_PX = 24'hFF8001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  theta;
  logic [0:0]  src_sel;
  logic [7:0]  brightness;
  logic        overrun_clr;
  logic [13:0] rd_addr;
  logic [0:0]  rd_src;
  logic [23:0] rd_data;
  logic [5:0]  px_idx;
  logic [23:0] px_out;
  logic        col_ready;
  logic        busy;
  logic        overrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic const_mode = 1'b0;

  always #5 clk = ~clk;

  pov_column_prefetch #(
    .LED_COUNT (LED_COUNT),
    .TEX_WIDTH (TEX_WIDTH),
    .THETA_BITS(THETA_BITS),
    .NUM_SRC   (2),
    .PX_BITS   (24)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .theta      (theta),
    .src_sel    (src_sel),
    .brightness (brightness),
    .overrun_clr(overrun_clr),
    .rd_addr    (rd_addr),
    .rd_src     (rd_src),
    .rd_data    (rd_data),
    .px_idx     (px_idx),
    .px_out     (px_out),
    .col_ready  (col_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Contents of the two source memories.
  function automatic logic [23:0] src_word(input int s, input int addr);
    if (const_mode) return CONST_PX;
    if (s == 0) return 24'(addr);
    return 24'((addr * 40503 + 12345) ^ (addr << 9));
  endfunction

  // Synchronous source memory with one cycle of read latency.
  always @(posedge clk) rd_data <= src_word(int'(rd_src), int'(rd_addr));

  // Expected pixel j of the column shown for angle th.
  function automatic logic [23:0] model_px(input int s, input int th, input int bri, input int j);
    int col;
    int px;
    int res;
    if (j >= LED_COUNT) return 24'd0;
    col = ((th * TEX_WIDTH) >> THETA_BITS) % TEX_WIDTH;
    px  = int'(src_word(s, j * TEX_WIDTH + col));
    res = 0;
    for (int b = 0; b < 3; b++) res += ((((px >> (8 * b)) & 255) * (bri + 1)) / 256) << (8 * b);
    return 24'(res);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for col_ready; checks latency, busy coverage and that the
  // source select stayed fixed for the whole fetch.
  task automatic wait_col(input string tag, input int exp_n, input int exp_src);
    int n = 0;
    int nb = 0;
    int nbad = 0;
    do begin
      tick();
      n++;
      if (busy) nb++;
      if (busy && int'(rd_src) != exp_src) nbad++;
    end while (!col_ready && n < 1000);
    check({tag, "_latency"}, n, exp_n);
    check({tag, "_busy"}, nb, exp_n);
    check({tag, "_rd_src"}, nbad, 0);
  endtask

  // Called in the swap cycle: skip past the swap edge, then read every pixel.
  task automatic read_column(input string tag, input int s, input int th, input int bri);
    tick();
    for (int j = 0; j < LED_COUNT; j++) begin
      px_idx = 6'(j);
      tick();
      check($sformatf("%s_px%0d", tag, j), px_out, model_px(s, th, bri, j));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_rd_src"}, rd_src, 0);
    check({tag, "_px_out"}, px_out, 0);
    check({tag, "_col_ready"}, col_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cur;
    int th;
    int s;
    int b;

    rst_n = 1'b0; theta = 6'd0; src_sel = 1'b0; brightness = 8'd255;
    overrun_clr = 1'b0; px_idx = 6'd5;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // First fetch starts straight out of reset.
    rst_n = 1'b1;
    wait_col("first", LED_COUNT + 2, 0);
    tick();
    check("first_swap_old", px_out, 0);
    check("first_pulse_len", col_ready, 0);
    check("first_idle", busy, 0);
    tick();
    check("first_px5", px_out, 24'h000500);

    // Angle steps
    theta = 6'd1;
    wait_col("th1", LED_COUNT + 2, 0);
    read_column("th1", 0, 1, 255);
    theta = 6'd63;
    wait_col("th63", LED_COUNT + 2, 0);
    read_column("th63", 0, 63, 255);
    px_idx = 6'd51; tick();
    check("th63_px51", px_out, 13308);
    px_idx = 6'd52; tick();
    check("px52_out_of_range", px_out, 0);
    px_idx = 6'd60; tick();
    check("px60_out_of_range", px_out, 0);

    // Theta moves at k=10: one extra back-to-back fetch for the newest theta.
    theta = 6'd10;
    repeat (11) tick();
    theta = 6'd20;
    repeat (2) tick();
    check("overrun_set", overrun, 1);
    wait_col("ovr_first", LED_COUNT + 2 - 13, 0);
    wait_col("ovr_extra", LED_COUNT + 2, 0);
    tick();
    check("ovr_no_third", busy, 0);
    read_column("ovr", 0, 20, 255);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    check("overrun_clr", overrun, 0);

    // Clear and a new overrun event in the same cycle: set wins.
    theta = 6'd30;
    repeat (5) tick();
    theta = 6'd31; overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_set_wins", overrun, 1);
    wait_col("sw_first", LED_COUNT + 2 - 6, 0);
    wait_col("sw_extra", LED_COUNT + 2, 0);
    read_column("sw", 0, 31, 255);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    check("overrun_clr2", overrun, 0);

    // Brightness sweep on a constant pixel
    const_mode = 1'b1;
    px_idx = 6'd0;
    theta = 6'd40; brightness = 8'd255;
    wait_col("b255", LED_COUNT + 2, 0);
    tick(); tick();
    check("b255_px", px_out, 24'hFF8001);
    theta = 6'd41; brightness = 8'd127;
    wait_col("b127", LED_COUNT + 2, 0);
    tick();
    check("b127_swap_old", px_out, 24'hFF8001);
    tick();
    check("b127_px", px_out, 24'h7F4000);
    theta = 6'd42; brightness = 8'd0;
    wait_col("b0", LED_COUNT + 2, 0);
    tick(); tick();
    check("b0_px", px_out, 24'h000000);
    const_mode = 1'b0;

    // Source select change mid-fetch only affects the next fetch.
    theta = 6'd50; src_sel = 1'b0; brightness = 8'd255;
    repeat (3) tick();
    src_sel = 1'b1;
    wait_col("src_hold", LED_COUNT + 2 - 3, 0);
    read_column("src_hold", 0, 50, 255);
    theta = 6'd51; brightness = 8'd200;
    wait_col("src_new", LED_COUNT + 2, 1);
    read_column("src_new", 1, 51, 200);

    // Randomized columns
    cur = 51;
    for (int it = 0; it < 8; it++) begin
      th = (cur + 1 + int'($urandom_range(0, 62))) % 64;
      s  = int'($urandom_range(0, 1));
      b  = int'($urandom_range(0, 255));
      theta = 6'(th); src_sel = 1'(s); brightness = 8'(b);
      wait_col($sformatf("rnd%0d", it), LED_COUNT + 2, s);
      read_column($sformatf("rnd%0d", it), s, th, b);
      cur = th;
    end

    // Reset in the middle of a fetch, with overrun already set.
    src_sel = 1'b0; brightness = 8'd255; px_idx = 6'd5;
    th = (cur + 7) % 64;
    theta = 6'(th);
    repeat (15) tick();
    th = (th + 3) % 64;
    theta = 6'(th);
    repeat (6) tick();
    check("pre_rst_overrun", overrun, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_col("post_rst", LED_COUNT + 2, 0);
    tick();
    check("post_rst_swap_old", px_out, 0);
    read_column("post_rst", 0, th, 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pov_column_prefetch.md
Name: pov_column_prefetch

Overview:
- Parametrised successor to the POV pixel path. It selects one of NUM_SRC pixel sources, such as the globe texture ROM or the CPU framebuffer.
- On every angular step it prefetches one full LED column into a double-buffered line store and scales each pixel by a global brightness.
- It serves the neopixel controller from the stable front buffer, so the source ROMs no longer need per-pixel, same-cycle address timing.
- Sits between theta_from_breakbeam / the source memories and neopixel_controller.

Parameters:
- LED_COUNT, 52, LEDs on the strip (pixels per column); 1..64.
- TEX_WIDTH, 256, columns per revolution; must be a power of two.
- THETA_BITS, 6, width of the angle index.
- NUM_SRC, 2, number of selectable pixel sources; >=1.
- PX_BITS, 24, pixel width; a multiple of 8 (GRB bytes).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- theta  in  THETA_BITS  current angle index.
- src_sel  in  SW  source select, where SW = max(1, clog2(NUM_SRC)).
- brightness  in  8  global brightness; 255 = unity.
- overrun_clr  in  1  single-cycle pulse; clears overrun.
- rd_addr  out  AW  source read address, where AW = clog2(TEX_WIDTH*LED_COUNT).
- rd_src  out  SW  source being read; external logic muxes rd_data from it.
- rd_data  in  PX_BITS  source read data; synchronous, 1-cycle latency.
- px_idx  in  6  LED index requested by neopixel_controller.
- px_out  out  PX_BITS  pixel for px_idx; 1-cycle latency.
- col_ready  out  1  1-cycle pulse when a new column is swapped in.
- busy  out  1  high in FETCH, DRAIN and SWAP.
- overrun  out  1  sticky flag: theta changed while a fetch was in progress.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; theta_q=0; first=1; pending=0.
  - Both buffers cleared to 0.
  - rd_addr=0, rd_src=0, px_out=0, col_ready=0, busy=0, overrun=0.
  - Reset asserted mid-fetch aborts the fetch; no partial swap occurs.
- theta is registered into theta_q every cycle. Change event = (theta != theta_q) or first==1. first clears when the first fetch starts.
- col = (theta * TEX_WIDTH) >> THETA_BITS, computed at full width (THETA_BITS + log2 TEX_WIDTH bits) then truncated to log2 TEX_WIDTH bits.
- On fetch start, col, theta and src_sel are latched. src_sel changes during a fetch have no effect until the next start, so there is no mixed-source column.
- FSM states:
  - IDLE: on a change event or pending, go to FETCH; k=0; clear pending.
  - FETCH: rd_addr = k*TEX_WIDTH + col_l; rd_src = src_l; k increments each cycle. After k = LED_COUNT-1, go to DRAIN.
  - DRAIN: one cycle, captures the last rd_data.
  - SWAP: front/back index toggles; col_ready=1 this cycle only. Next state is FETCH if pending, otherwise IDLE.
- Write-back: rd_data returned in the cycle after address k is written to back[k].
- Per-byte scaling: out_byte = (in_byte * (brightness+1)) >> 8. brightness=255 is exact identity; brightness=0 yields 0 for inputs below 256, i.e. always 0.
- Column timing: col_ready asserts LED_COUNT+1 cycles after the FETCH entry cycle. A fetch-to-fetch cycle is therefore LED_COUNT+2 cycles.
- Theta change during FETCH, DRAIN or SWAP:
  - Sets pending and sets overrun.
  - Only the newest theta is kept; it is re-latched at the next start.
  - The in-progress fetch completes and swaps normally.
- overrun_clr clears overrun. If a new overrun event occurs in the same cycle, set wins.
- px_out:
  - px_out <= front[px_idx] registered.
  - If px_idx >= LED_COUNT, px_out <= 0.
  - On a swap cycle, a read in that cycle returns old-front data; the next cycle returns new data.
- rd_addr holds its last value outside FETCH. Consumers must ignore it when busy=0 or in DRAIN/SWAP.

Test Plan:
- Reset release, theta=0, src_sel=0, brightness=255, source returns addr as data → FETCH begins immediately. 53 cycles later col_ready pulses. px_idx=5 yields px_out=0x000500 (5*256+0) one cycle later.
- theta steps 0→1, then 63 → col=4 then col=252. For theta=63, px_idx=51 returns 51*256+252 = 13308. busy is high for exactly 54 cycles per fetch.
- Theta changes at FETCH k=10 → overrun=1; exactly one extra fetch runs back-to-back for the newest theta. overrun_clr pulse → 0. Simultaneous clr and new overrun event → remains 1.
- Brightness sweep with pixel 0xFF8001:
  - b=255 → 0xFF8001.
  - b=127 → 0x7F4000.
  - b=0 → 0x000000.
- src_sel toggled 0→1 mid-fetch → all 52 rd_src samples in that fetch =0; the next fetch uses 1. px_idx=60 → px_out=0.
- rst_n pulsed low at FETCH k=20 → all outputs 0 asynchronously; after release, a fresh full fetch occurs with no col_ready before 53 cycles.
